// File: rtl/byte_mem_pkg.sv
// Shared constants for the byte-serial memory.
// Beat mode encodings and default sizing.
package byte_mem_pkg;

  localparam logic MODE_READ  = 1'b0;
  localparam logic MODE_WRITE = 1'b1;

  localparam int DEF_DEPTH_BYTES = 4096;
  localparam int DEF_WAIT_CYCLES = 1;
  localparam int DEF_RD_LAT      = 2;

endpackage

// File: rtl/byte_serial_mem_if.sv
// Beat bus between requester and byte memory.
// master = requester, slave = memory.
interface byte_serial_mem_if;

  logic        mode;
  logic        valid;
  logic        ready;
  logic [63:0] addr;
  logic [7:0]  w_data;
  logic        r_data_valid;
  logic [7:0]  r_data;
  logic        addr_err;

  modport master (
    output mode, valid, addr, w_data,
    input  ready, r_data_valid, r_data, addr_err
  );

  modport slave (
    input  mode, valid, addr, w_data,
    output ready, r_data_valid, r_data, addr_err
  );

endinterface

// File: rtl/rd_delay_pipe.sv
// Fixed-latency valid/data shift pipe for read returns.
// Data is forced to zero in any slot whose valid is low.
module rd_delay_pipe #(
  parameter int LAT = 2,
  parameter int W   = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  output logic [W-1:0] out_data
);

  logic [LAT-1:0]        vld_q, vld_d;
  logic [LAT-1:0][W-1:0] dat_q, dat_d;

  // shift every slot one step toward the output
  always_comb begin
    vld_d    = vld_q;
    dat_d    = dat_q;
    vld_d[0] = in_valid;
    dat_d[0] = in_valid ? in_data : '0;
    for (int i = 1; i < LAT; i++) begin
      vld_d[i] = vld_q[i-1];
      dat_d[i] = dat_q[i-1];
    end
  end

  // pipe registers; reset drops in-flight reads
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q <= '0;
      dat_q <= '0;
    end else begin
      vld_q <= vld_d;
      dat_q <= dat_d;
    end
  end

  assign out_valid = vld_q[LAT-1];
  assign out_data  = dat_q[LAT-1];

endmodule

// File: rtl/byte_serial_mem.sv
// Byte-serial memory with per-beat wait states.
// Define BYTE_MEM_PERF_CNT_EN for rd_cnt/wr_cnt.
module byte_serial_mem
  import byte_mem_pkg::*;
#(
  parameter int DEPTH_BYTES = DEF_DEPTH_BYTES,
  parameter int WAIT_CYCLES = DEF_WAIT_CYCLES,
  parameter int RD_LAT      = DEF_RD_LAT
) (
  input  logic               clk,
  input  logic               rst,
  byte_serial_mem_if.slave   bus
`ifdef BYTE_MEM_PERF_CNT_EN
  ,
  output logic [31:0]        rd_cnt,
  output logic [31:0]        wr_cnt
`endif
);

  localparam int AW = $clog2(DEPTH_BYTES);
  localparam logic [3:0] WAIT_MAX = 4'(WAIT_CYCLES);

  logic [3:0]    wait_cnt_q, wait_cnt_d;
  logic          addr_err_q, addr_err_d;
  logic          ready;
  logic          accept;
  logic          in_range;
  logic          rd_acc;
  logic          wr_acc;
  logic [AW-1:0] idx;
  logic [7:0]    rd_byte;
  logic [7:0]    mem [DEPTH_BYTES];

  assign ready    = bus.valid && !rst &&
                    (wait_cnt_q == WAIT_MAX);
  assign accept   = bus.valid && ready;
  assign in_range = (bus.addr >> AW) == 64'd0;
  assign idx      = bus.addr[AW-1:0];
  assign rd_acc   = accept && (bus.mode == MODE_READ);
  assign wr_acc   = accept && (bus.mode == MODE_WRITE) &&
                    in_range;
  assign rd_byte  = in_range ? mem[idx] : 8'h00;

  // stall counter; mode/addr changes do not clear it
  always_comb begin
    wait_cnt_d = wait_cnt_q;
    addr_err_d = accept && !in_range;
    if (!bus.valid || accept) begin
      wait_cnt_d = '0;
    end else if (wait_cnt_q != WAIT_MAX) begin
      wait_cnt_d = wait_cnt_q + 4'd1;
    end
  end

  // control state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt_q <= '0;
      addr_err_q <= 1'b0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
      addr_err_q <= addr_err_d;
    end
  end

  // storage array keeps its contents across reset
  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem[idx] <= bus.w_data;
    end
  end

  rd_delay_pipe #(
    .LAT (RD_LAT),
    .W   (8)
  ) u_rd_pipe (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (rd_acc),
    .in_data   (rd_byte),
    .out_valid (bus.r_data_valid),
    .out_data  (bus.r_data)
  );

  assign bus.ready    = ready;
  assign bus.addr_err = addr_err_q;

`ifdef BYTE_MEM_PERF_CNT_EN
  logic [31:0] rd_cnt_q, rd_cnt_d;
  logic [31:0] wr_cnt_q, wr_cnt_d;

  // accepted-beat counters, wrapping
  always_comb begin
    rd_cnt_d = rd_cnt_q;
    wr_cnt_d = wr_cnt_q;
    if (accept && bus.mode == MODE_READ) begin
      rd_cnt_d = rd_cnt_q + 32'd1;
    end
    if (accept && bus.mode == MODE_WRITE) begin
      wr_cnt_d = wr_cnt_q + 32'd1;
    end
  end

  // counter registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_cnt_q <= '0;
      wr_cnt_q <= '0;
    end else begin
      rd_cnt_q <= rd_cnt_d;
      wr_cnt_q <= wr_cnt_d;
    end
  end

  assign rd_cnt = rd_cnt_q;
  assign wr_cnt = wr_cnt_q;
`endif

endmodule

// File: tb/tb_byte_serial_mem.sv
// Bench for byte_serial_mem: default instance plus
// a zero-wait instance for back-to-back reads.
module tb_byte_serial_mem;
  import byte_mem_pkg::*;

  typedef struct {
    logic [7:0] data;
    int         due;
  } rsp_t;

  typedef struct {
    logic        m;
    logic [63:0] a;
    logic [7:0]  wd;
    logic [7:0]  exp;
    logic        err;
  } vec_t;

  logic clk;
  logic rst;
  int   cyc;
  int   checks;
  int   fails;
  int   tally_rd;
  int   tally_wr;
  rsp_t qa[$];
  rsp_t qb[$];

  byte_serial_mem_if ia();
  byte_serial_mem_if ib();

`ifdef BYTE_MEM_PERF_CNT_EN
  logic [31:0] rd_cnt_a, wr_cnt_a;
  logic [31:0] rd_cnt_b, wr_cnt_b;
`endif

  byte_serial_mem dut_a (
    .clk (clk),
    .rst (rst),
    .bus (ia)
`ifdef BYTE_MEM_PERF_CNT_EN
    ,
    .rd_cnt (rd_cnt_a),
    .wr_cnt (wr_cnt_a)
`endif
  );

  byte_serial_mem #(
    .WAIT_CYCLES (0)
  ) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (ib)
`ifdef BYTE_MEM_PERF_CNT_EN
    ,
    .rd_cnt (rd_cnt_b),
    .wr_cnt (wr_cnt_b)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  function automatic void chk(string n,
                              logic [63:0] act,
                              logic [63:0] req);
    checks++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s act=%0h req=%0h cyc=%0d",
               n, act, req, cyc);
    end
  endfunction

  // return monitor, instance a
  always @(negedge clk) begin : mon_a
    rsp_t e;
    if (!rst) begin
      if (ia.r_data_valid) begin
        if (qa.size() == 0) begin
          checks++;
          fails++;
          $display("FAIL a_stray_rvalid act=1 req=0 cyc=%0d",
                   cyc);
        end else begin
          e = qa.pop_front();
          chk("a_rdata", 64'(ia.r_data), 64'(e.data));
          chk("a_rlat", 64'(cyc), 64'(e.due));
        end
      end else begin
        chk("a_rdata_idle", 64'(ia.r_data), 64'h0);
      end
    end
  end

  // return monitor, instance b
  always @(negedge clk) begin : mon_b
    rsp_t e;
    if (!rst) begin
      if (ib.r_data_valid) begin
        if (qb.size() == 0) begin
          checks++;
          fails++;
          $display("FAIL b_stray_rvalid act=1 req=0 cyc=%0d",
                   cyc);
        end else begin
          e = qb.pop_front();
          chk("b_rdata", 64'(ib.r_data), 64'(e.data));
          chk("b_rlat", 64'(cyc), 64'(e.due));
        end
      end else begin
        chk("b_rdata_idle", 64'(ib.r_data), 64'h0);
      end
    end
  end

  // one isolated beat on instance a (WAIT_CYCLES=1)
  task automatic beat_a(input logic m,
                        input logic [63:0] a,
                        input logic [7:0] wd,
                        input logic [7:0] exp_rd,
                        input logic exp_err);
    int waited;
    int acc_cyc;
    bit got;
    waited  = 0;
    acc_cyc = 0;
    got     = 1'b0;
    @(posedge clk);
    #1;
    ia.mode   = m;
    ia.addr   = a;
    ia.w_data = wd;
    ia.valid  = 1'b1;
    for (int k = 0; k < 40 && !got; k++) begin
      @(negedge clk);
      if (ia.ready) begin
        got     = 1'b1;
        acc_cyc = cyc;
      end else begin
        waited++;
      end
    end
    chk("a_accept", 64'(got), 64'd1);
    if (got) begin
      chk("a_wait", 64'(waited), 64'd1);
      if (m == MODE_READ) begin
        qa.push_back('{data: exp_rd, due: acc_cyc + 2});
        tally_rd++;
      end else begin
        tally_wr++;
      end
    end
    @(posedge clk);
    #1;
    ia.valid = 1'b0;
    @(negedge clk);
    chk("a_addr_err", 64'(ia.addr_err), 64'(exp_err));
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while ((qa.size() != 0 || qb.size() != 0) &&
           n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("drain", 64'(qa.size() + qb.size()), 64'd0);
  endtask

  vec_t vecs[20];

  initial begin : main
    bit got;
    bit r;
    checks   = 0;
    fails    = 0;
    cyc      = 0;
    tally_rd = 0;
    tally_wr = 0;

    vecs[0]  = '{MODE_WRITE, 64'h0,    8'h11, 8'h00, 1'b0};
    vecs[1]  = '{MODE_WRITE, 64'h10,   8'hA5, 8'h00, 1'b0};
    vecs[2]  = '{MODE_WRITE, 64'h11,   8'h3C, 8'h00, 1'b0};
    vecs[3]  = '{MODE_WRITE, 64'hFFF,  8'h7E, 8'h00, 1'b0};
    vecs[4]  = '{MODE_WRITE, 64'h1010, 8'hFF, 8'h00, 1'b1};
    vecs[5]  = '{MODE_WRITE, 64'h8000_0000_0000_0011,
                 8'hEE, 8'h00, 1'b1};
    vecs[6]  = '{MODE_READ,  64'h10,   8'h00, 8'hA5, 1'b0};
    vecs[7]  = '{MODE_READ,  64'h11,   8'h00, 8'h3C, 1'b0};
    vecs[8]  = '{MODE_READ,  64'hFFF,  8'h00, 8'h7E, 1'b0};
    vecs[9]  = '{MODE_READ,  64'h2000, 8'h00, 8'h00, 1'b1};
    vecs[10] = '{MODE_WRITE, 64'h2000, 8'h55, 8'h00, 1'b1};
    vecs[11] = '{MODE_READ,  64'h2000, 8'h00, 8'h00, 1'b1};
    vecs[12] = '{MODE_READ,  64'h0,    8'h00, 8'h11, 1'b0};
    vecs[13] = '{MODE_WRITE, 64'h11,   8'hC3, 8'h00, 1'b0};
    vecs[14] = '{MODE_READ,  64'h11,   8'h00, 8'hC3, 1'b0};
    vecs[15] = '{MODE_READ,  64'h30,   8'h00, 8'h90, 1'b0};
    vecs[16] = '{MODE_READ,  64'h31,   8'h00, 8'h91, 1'b0};
    vecs[17] = '{MODE_READ,  64'h32,   8'h00, 8'h92, 1'b0};
    vecs[18] = '{MODE_READ,  64'h33,   8'h00, 8'h93, 1'b0};
    vecs[19] = '{MODE_READ,  64'h10,   8'h00, 8'hA5, 1'b0};

    rst       = 1'b1;
    ia.valid  = 1'b0;
    ia.mode   = MODE_READ;
    ia.addr   = '0;
    ia.w_data = '0;
    ib.valid  = 1'b1;
    ib.mode   = MODE_READ;
    ib.addr   = '0;
    ib.w_data = '0;

    // reset state, with b requesting during reset
    repeat (2) @(negedge clk);
    chk("rst_ready_b", 64'(ib.ready), 64'd0);
    chk("rst_rvalid_a", 64'(ia.r_data_valid), 64'd0);
    chk("rst_rdata_a", 64'(ia.r_data), 64'd0);
    chk("rst_err_a", 64'(ia.addr_err), 64'd0);
    chk("rst_rvalid_b", 64'(ib.r_data_valid), 64'd0);
    ib.valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;

    // continuous write burst: ready every second cycle
    @(posedge clk);
    #1;
    ia.mode   = MODE_WRITE;
    ia.addr   = 64'h30;
    ia.w_data = 8'h90;
    ia.valid  = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      r = ia.ready;
      chk("a_burst_ready", 64'(r), 64'(k % 2));
      if (r) tally_wr++;
      @(posedge clk);
      #1;
      if (r) begin
        ia.addr   = ia.addr + 64'd1;
        ia.w_data = ia.w_data + 8'd1;
      end
    end
    ia.valid = 1'b0;

    for (int i = 0; i < 20; i++) begin
      beat_a(vecs[i].m, vecs[i].a, vecs[i].wd,
             vecs[i].exp, vecs[i].err);
    end
    drain(20);

`ifdef BYTE_MEM_PERF_CNT_EN
    chk("a_rd_cnt", 64'(rd_cnt_a), 64'(tally_rd));
    chk("a_wr_cnt", 64'(wr_cnt_a), 64'(tally_wr));
`endif

    // reset one cycle after a read accept
    @(posedge clk);
    #1;
    ia.mode  = MODE_READ;
    ia.addr  = 64'h10;
    ia.valid = 1'b1;
    got = 1'b0;
    for (int k = 0; k < 40 && !got; k++) begin
      @(negedge clk);
      got = ia.ready;
    end
    chk("a_rst_accept", 64'(got), 64'd1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    chk("a_rst_ready", 64'(ia.ready), 64'd0);
    chk("a_rst_rvalid", 64'(ia.r_data_valid), 64'd0);
    chk("a_rst_rdata", 64'(ia.r_data), 64'd0);
    chk("a_rst_err", 64'(ia.addr_err), 64'd0);
    @(negedge clk);
    chk("a_rst_ready2", 64'(ia.ready), 64'd0);
    chk("a_rst_rvalid2", 64'(ia.r_data_valid), 64'd0);
    ia.valid = 1'b0;
    tally_rd = 0;
    tally_wr = 0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (5) @(negedge clk);
    beat_a(MODE_READ, 64'h10, 8'h00, 8'hA5, 1'b0);
    beat_a(MODE_READ, 64'hFFF, 8'h00, 8'h7E, 1'b0);
    drain(20);

    // zero-wait instance: preload then 8 back-to-back reads
    @(posedge clk);
    #1;
    ib.mode  = MODE_WRITE;
    ib.valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      ib.addr   = 64'h20 + 64'(i);
      ib.w_data = 8'(i);
      @(negedge clk);
      chk("b_wr_ready", 64'(ib.ready), 64'd1);
      @(posedge clk);
      #1;
    end
    ib.mode = MODE_READ;
    for (int i = 0; i < 8; i++) begin
      ib.addr = 64'h20 + 64'(i);
      @(negedge clk);
      chk("b_rd_ready", 64'(ib.ready), 64'd1);
      qb.push_back('{data: 8'(i), due: cyc + 2});
      @(posedge clk);
      #1;
    end
    ib.valid = 1'b0;
    drain(20);

`ifdef BYTE_MEM_PERF_CNT_EN
    chk("a_rd_cnt2", 64'(rd_cnt_a), 64'(tally_rd));
    chk("b_rd_cnt", 64'(rd_cnt_b), 64'd8);
    chk("b_wr_cnt", 64'(wr_cnt_b), 64'd8);
`endif

    repeat (4) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, fails);
    $finish;
  end

endmodule

// File: doc/byte_serial_mem.md
BYTE_SERIAL_MEM -- requirements
Module: byte_serial_mem

Interface
REQ-001 Parameter DEPTH_BYTES, default 4096, number of byte locations in the storage array (power of two).
REQ-002 Parameter WAIT_CYCLES, default 1, number of stall cycles inserted before each beat is accepted (0..15).
REQ-003 Parameter RD_LAT, default 2, number of cycles from read-beat acceptance to r_data_valid (1..8).
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst  input  1  reset; asynchronous and active-high.
REQ-006 mode  input  1  0 = read beat, 1 = write beat.
REQ-007 valid  input  1  requester presents a beat.
REQ-008 ready  output  1  beat accepted this cycle when valid && ready.
REQ-009 addr  input  64  byte address of the beat.
REQ-010 w_data  input  8  write byte.
REQ-011 r_data_valid  output  1  one-cycle strobe qualifying r_data.
REQ-012 r_data  output  8  returned read byte.
REQ-013 addr_err  output  1  one-cycle strobe flagging an out-of-range beat.

Function
REQ-014 Accept = valid && ready; exactly one beat SHALL be consumed per accept cycle.
REQ-015 wait_cnt (4 bit) SHALL increment while valid && !ready, saturate at WAIT_CYCLES, and clear on accept or when valid is low.
REQ-016 ready SHALL equal valid && (wait_cnt == WAIT_CYCLES), so WAIT_CYCLES=0 accepts every valid cycle and WAIT_CYCLES=1 accepts every second cycle of a continuous burst.
REQ-017 Write accept with addr < DEPTH_BYTES SHALL store w_data at mem[addr] on the accept edge.
REQ-018 Read accept SHALL sample mem[addr] on the accept edge; r_data_valid/r_data SHALL assert exactly RD_LAT cycles after the accept cycle.
REQ-019 Read pipeline SHALL sustain one read per cycle with no bubbles and preserve order; back-to-back returns are permitted.
REQ-020 Read of an address written in an earlier cycle SHALL return the new byte; same-cycle read and write cannot occur (one beat per cycle).
REQ-021 Beat with addr >= DEPTH_BYTES: write SHALL be dropped, read SHALL return 0x00 at normal latency, and addr_err SHALL pulse in the cycle after accept.
REQ-022 r_data SHALL be 0x00 whenever r_data_valid is low.
REQ-023 Changes to mode/addr while valid is high and not yet accepted SHALL NOT reset wait_cnt.

Reset
REQ-024 While rst is high: ready=0, r_data_valid=0, r_data=0x00, addr_err=0, wait_cnt=0, all pipeline valid bits cleared.
REQ-025 Reset mid-burst SHALL discard in-flight reads (no late r_data_valid); the storage array SHALL NOT be reset.

Configuration
REQ-026 With BYTE_MEM_PERF_CNT_EN defined, outputs rd_cnt[31:0] and wr_cnt[31:0] SHALL count accepted read/write beats (wrapping, reset to 0); without it those ports and counters SHALL NOT exist.

Structure
REQ-027 Package byte_mem_pkg SHALL hold MODE_READ/MODE_WRITE constants and default values of DEPTH_BYTES, WAIT_CYCLES, RD_LAT.
REQ-028 Sub-module rd_delay_pipe SHALL implement the RD_LAT-deep valid/data shift pipeline.

Verification
REQ-029 WAIT_CYCLES=1: write 0xA5 to addr 0x10, hold valid -> ready low cycle 1, high cycle 2, mem[0x10]=0xA5.
REQ-030 RD_LAT=2: read addr 0x10 accepted cycle N -> r_data_valid high only in cycle N+2 with r_data=0xA5.
REQ-031 WAIT_CYCLES=0: 8 consecutive reads of 0x20..0x27 preloaded 0x00..0x07 -> 8 consecutive strobes returning 0x00..0x07 in order.
REQ-032 Read addr 0x2000 with DEPTH_BYTES=4096 -> addr_err pulse cycle N+1, r_data=0x00 at N+2; write to same addr leaves array unchanged.
REQ-033 Assert rst one cycle after a read accept -> no r_data_valid afterwards, ready=0 during reset, previously written bytes still readable.
REQ-034 BYTE_MEM_PERF_CNT_EN defined: 3 writes + 5 reads -> wr_cnt=3, rd_cnt=5.
